// File: rtl/graphic_system.sv
// Clear/blit engine writing the back half of a double-buffered RGB565 framebuffer, plus scanout of the front half.
// Clear writes one pixel per clock; blit issues one read per pixel and stalls until gpu_MemValid; video outputs lag the counters by one clock.
module graphic_system #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int H_BLANK   = 80,
  parameter int V_BLANK   = 45
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        swapBuffers,
  input  logic        isVSynced,
  output logic [31:0] gpu_MemAddr,
  output logic        gpu_MemRead,
  input  logic [15:0] gpu_MemData,
  input  logic        gpu_MemValid,
  input  logic [31:0] gpu_CtrlAddress,
  input  logic [15:0] gpu_CtrlAddressX,
  input  logic [15:0] gpu_CtrlAddressY,
  input  logic [15:0] gpu_CtrlImageWidth,
  input  logic [10:0] gpu_CtrlWidth,
  input  logic [9:0]  gpu_CtrlHeight,
  input  logic [10:0] gpu_CtrlX,
  input  logic [9:0]  gpu_CtrlY,
  input  logic        gpu_CtrlDraw,
  input  logic [15:0] gpu_CtrlClearColor,
  input  logic        gpu_CtrlClear,
  output logic        gpu_CtrlBusy,
  output logic        hdmi_vSync,
  output logic        video_hSync,
  output logic        video_de,
  output logic [15:0] video_pixel
);

  localparam int PIX     = FB_WIDTH * FB_HEIGHT;
  localparam int AW      = $clog2(2 * PIX);
  localparam int H_TOTAL = FB_WIDTH + H_BLANK;
  localparam int V_TOTAL = FB_HEIGHT + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {IDLE, CLEAR, REQ, WAIT} state_t;

  state_t        state;
  logic [31:0]   base;
  logic [15:0]   srcX, srcY, stride, color;
  logic [10:0]   width, dstX, i;
  logic [9:0]    height, dstY, j;
  logic          drawBuf, front, swapPending;
  logic [AW-1:0] clrIdx;

  logic [31:0]   srcRow, srcOff, reqAddr;
  logic [11:0]   dx;
  logic [10:0]   dy;
  logic          inRange;
  logic [AW-1:0] dstIdx, wrIdx, wrAddr, rdIdx, rdAddr;
  logic          wrEn;
  logic [15:0]   wrData, rdData;

  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic          active, lastPos;

  logic [15:0]   fb [0:2*PIX-1];

  always_comb begin
    srcRow  = {16'b0, srcY} + {22'b0, j};
    srcOff  = srcRow * {16'b0, stride} + {16'b0, srcX} + {21'b0, i};
    reqAddr = base + (srcOff << 1);
    dx      = {1'b0, dstX} + {1'b0, i};
    dy      = {1'b0, dstY} + {1'b0, j};
    inRange = (dx < 12'(FB_WIDTH)) && (dy < 11'(FB_HEIGHT));
    dstIdx  = AW'(dy) * AW'(FB_WIDTH) + AW'(dx);
  end

  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = clrIdx;
    wrData = color;
    if (state == CLEAR) begin
      wrEn = 1'b1;
    end else if (state == WAIT && gpu_MemValid && inRange) begin
      wrEn   = 1'b1;
      wrIdx  = dstIdx;
      wrData = gpu_MemData;
    end
    wrAddr = drawBuf ? AW'(PIX) + wrIdx : wrIdx;
  end

  always_comb begin
    active  = (hCnt < HW'(FB_WIDTH)) && (vCnt < VW'(FB_HEIGHT));
    lastPos = (hCnt == HW'(H_TOTAL - 1)) && (vCnt == VW'(V_TOTAL - 1));
    rdIdx   = active ? AW'(vCnt) * AW'(FB_WIDTH) + AW'(hCnt) : '0;
    rdAddr  = front ? AW'(PIX) + rdIdx : rdIdx;
  end

  // Framebuffer contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wrEn) fb[wrAddr] <= wrData;
    rdData <= fb[rdAddr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      gpu_CtrlBusy <= 1'b0;
      gpu_MemRead  <= 1'b0;
      gpu_MemAddr  <= '0;
      base         <= '0;
      srcX         <= '0;
      srcY         <= '0;
      stride       <= '0;
      color        <= '0;
      width        <= '0;
      height       <= '0;
      dstX         <= '0;
      dstY         <= '0;
      i            <= '0;
      j            <= '0;
      drawBuf      <= 1'b0;
      clrIdx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gpu_CtrlClear) begin
            color        <= gpu_CtrlClearColor;
            drawBuf      <= ~front;
            clrIdx       <= '0;
            gpu_CtrlBusy <= 1'b1;
            state        <= CLEAR;
          end else if (gpu_CtrlDraw) begin
            base         <= gpu_CtrlAddress;
            srcX         <= gpu_CtrlAddressX;
            srcY         <= gpu_CtrlAddressY;
            stride       <= gpu_CtrlImageWidth;
            width        <= gpu_CtrlWidth;
            height       <= gpu_CtrlHeight;
            dstX         <= gpu_CtrlX;
            dstY         <= gpu_CtrlY;
            drawBuf      <= ~front;
            i            <= '0;
            j            <= '0;
            gpu_CtrlBusy <= 1'b1;
            state        <= REQ;
          end
        end
        CLEAR: begin
          if (clrIdx == AW'(PIX - 1)) begin
            gpu_CtrlBusy <= 1'b0;
            state        <= IDLE;
          end else begin
            clrIdx <= clrIdx + 1'b1;
          end
        end
        REQ: begin
          if (width == '0 || height == '0) begin
            gpu_CtrlBusy <= 1'b0;
            state        <= IDLE;
          end else begin
            gpu_MemRead <= 1'b1;
            gpu_MemAddr <= reqAddr;
            state       <= WAIT;
          end
        end
        WAIT: begin
          gpu_MemRead <= 1'b0;
          if (gpu_MemValid) begin
            if (i == width - 11'd1) begin
              i <= '0;
              if (j == height - 10'd1) begin
                gpu_CtrlBusy <= 1'b0;
                state        <= IDLE;
              end else begin
                j     <= j + 10'd1;
                state <= REQ;
              end
            end else begin
              i     <= i + 11'd1;
              state <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A swap request arriving while one is pending folds into it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hCnt        <= '0;
      vCnt        <= '0;
      front       <= 1'b0;
      swapPending <= 1'b0;
      video_de    <= 1'b0;
      video_hSync <= 1'b0;
      hdmi_vSync  <= 1'b0;
    end else begin
      if (hCnt == HW'(H_TOTAL - 1)) begin
        hCnt <= '0;
        vCnt <= (vCnt == VW'(V_TOTAL - 1)) ? '0 : vCnt + 1'b1;
      end else begin
        hCnt <= hCnt + 1'b1;
      end
      if (swapPending && (!isVSynced || lastPos)) begin
        front       <= ~front;
        swapPending <= 1'b0;
      end else if (swapBuffers) begin
        swapPending <= 1'b1;
      end
      video_de    <= active;
      video_hSync <= hCnt >= HW'(FB_WIDTH);
      hdmi_vSync  <= vCnt >= VW'(FB_HEIGHT);
    end
  end

  assign video_pixel = video_de ? rdData : 16'h0000;

endmodule

// File: tb/tb_graphic_system.sv
// Bench for graphic_system on an 8x4 framebuffer: source-read and scanout-pixel scoreboards.
module tb_graphic_system;
  localparam int W = 8, H = 4, PIX = 32, FRAME = 72;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        swapBuffers, isVSynced;
  logic [31:0] gpu_MemAddr;
  logic        gpu_MemRead;
  logic [15:0] gpu_MemData;
  logic        gpu_MemValid;
  logic [31:0] gpu_CtrlAddress;
  logic [15:0] gpu_CtrlAddressX, gpu_CtrlAddressY, gpu_CtrlImageWidth, gpu_CtrlClearColor;
  logic [10:0] gpu_CtrlWidth, gpu_CtrlX;
  logic [9:0]  gpu_CtrlHeight, gpu_CtrlY;
  logic        gpu_CtrlDraw, gpu_CtrlClear, gpu_CtrlBusy;
  logic        hdmi_vSync, video_hSync, video_de;
  logic [15:0] video_pixel;

  graphic_system #(.FB_WIDTH(8), .FB_HEIGHT(4), .H_BLANK(4), .V_BLANK(2)) dut (
    .clk(clk), .resetn(resetn), .swapBuffers(swapBuffers), .isVSynced(isVSynced),
    .gpu_MemAddr(gpu_MemAddr), .gpu_MemRead(gpu_MemRead), .gpu_MemData(gpu_MemData),
    .gpu_MemValid(gpu_MemValid), .gpu_CtrlAddress(gpu_CtrlAddress),
    .gpu_CtrlAddressX(gpu_CtrlAddressX), .gpu_CtrlAddressY(gpu_CtrlAddressY),
    .gpu_CtrlImageWidth(gpu_CtrlImageWidth), .gpu_CtrlWidth(gpu_CtrlWidth),
    .gpu_CtrlHeight(gpu_CtrlHeight), .gpu_CtrlX(gpu_CtrlX), .gpu_CtrlY(gpu_CtrlY),
    .gpu_CtrlDraw(gpu_CtrlDraw), .gpu_CtrlClearColor(gpu_CtrlClearColor),
    .gpu_CtrlClear(gpu_CtrlClear), .gpu_CtrlBusy(gpu_CtrlBusy), .hdmi_vSync(hdmi_vSync),
    .video_hSync(video_hSync), .video_de(video_de), .video_pixel(video_pixel)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0, readCnt = 0;
  logic [31:0] addrQ[$];
  logic [15:0] pixQ[$];
  logic [15:0] bufs[2][PIX];
  int          frontM = 0;
  logic [31:0] rspAddr, rspExp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [31:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Source memory: answers each strobe one cycle later; unexpected reads compare against a sentinel.
  initial begin
    gpu_MemValid = 1'b0;
    gpu_MemData  = '0;
    forever begin
      @(negedge clk);
      if (gpu_MemRead) begin
        rspAddr = gpu_MemAddr;
        rspExp  = (addrQ.size() > 0) ? addrQ.pop_front() : 32'hDEAD_BEEF;
        readCnt++;
        chk("memAddr", rspAddr, rspExp);
        @(posedge clk); #1;
        gpu_MemValid = 1'b1;
        gpu_MemData  = memWord(rspAddr);
        @(posedge clk); #1;
        gpu_MemValid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic waitBusy(output int n);
    bit done = 0;
    n = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (gpu_CtrlBusy) n++;
      else if (n > 0) done = 1;
    end
    chk("busyDone", {31'b0, done}, 32'd1);
  endtask

  task automatic doDraw(input logic [31:0] addr, input logic [15:0] ax, ay, iw,
                        input logic [10:0] w, x, input logic [9:0] h, y, output int n);
    int tgt = 1 - frontM;
    for (int jj = 0; jj < int'(h); jj++)
      for (int ii = 0; ii < int'(w); ii++) begin
        logic [31:0] a;
        a = addr + ((32'(ay) + 32'(jj)) * 32'(iw) + 32'(ax) + 32'(ii)) * 32'd2;
        addrQ.push_back(a);
        if (int'(x) + ii < W && int'(y) + jj < H) bufs[tgt][(int'(y) + jj) * W + int'(x) + ii] = memWord(a);
      end
    @(posedge clk); #1;
    gpu_CtrlAddress = addr; gpu_CtrlAddressX = ax; gpu_CtrlAddressY = ay;
    gpu_CtrlImageWidth = iw; gpu_CtrlWidth = w; gpu_CtrlHeight = h;
    gpu_CtrlX = x; gpu_CtrlY = y; gpu_CtrlDraw = 1'b1;
    @(posedge clk); #1;
    gpu_CtrlDraw = 1'b0;
    // Operands must have been captured at acceptance.
    gpu_CtrlAddress = 32'hFFFF_0000; gpu_CtrlAddressX = 16'h7; gpu_CtrlAddressY = 16'h9;
    gpu_CtrlImageWidth = 16'h3; gpu_CtrlX = '0; gpu_CtrlY = '0;
    waitBusy(n);
    repeat (3) @(negedge clk);
    chk("drawReadsLeft", addrQ.size(), 0);
  endtask

  task automatic doClear(input logic [15:0] color, input logic withDraw, output int n);
    bit done = 0;
    int r0 = readCnt;
    for (int k = 0; k < PIX; k++) bufs[1 - frontM][k] = color;
    @(posedge clk); #1;
    gpu_CtrlAddress = 32'h3000; gpu_CtrlAddressX = '0; gpu_CtrlAddressY = '0;
    gpu_CtrlImageWidth = 16'd2; gpu_CtrlWidth = 11'd2; gpu_CtrlHeight = 10'd2;
    gpu_CtrlClearColor = color; gpu_CtrlClear = 1'b1; gpu_CtrlDraw = withDraw;
    @(posedge clk); #1;
    gpu_CtrlClear = 1'b0; gpu_CtrlDraw = 1'b0;
    n = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (gpu_CtrlBusy) n++;
      else if (n > 0) done = 1;
      gpu_CtrlDraw = (n == 5);
      if (n == 5) gpu_CtrlClearColor = 16'hFFFF;
    end
    gpu_CtrlDraw = 1'b0;
    repeat (6) @(negedge clk);
    chk("clearBusyCycles", n, PIX);
    chk("clearReads", readCnt - r0, 0);
  endtask

  task automatic swapNow();
    @(posedge clk); #1;
    isVSynced = 1'b0; swapBuffers = 1'b1;
    @(posedge clk); #1;
    swapBuffers = 1'b0;
    frontM = 1 - frontM;
    repeat (3) @(posedge clk);
  endtask

  // Scans one whole frame, comparing de pixels against model buffer b; swapAt>=0 issues vsynced swaps mid-frame.
  task automatic checkFrame(input int b, input int swapAt, input string tag);
    bit   found = 0;
    logic prev;
    int   de = 0, vs = 0, hs = 0, nz = 0;
    @(negedge clk);
    prev = hdmi_vSync;
    for (int t = 0; t < 400 && !found; t++) begin
      @(negedge clk);
      if (prev && !hdmi_vSync) found = 1;
      else prev = hdmi_vSync;
    end
    chk("frameStartSeen", {31'b0, found}, 32'd1);
    for (int k = 0; k < PIX; k++) pixQ.push_back(bufs[b][k]);
    for (int n = 0; n < FRAME; n++) begin
      if (n > 0) @(negedge clk);
      if (video_de) begin
        de++;
        if (pixQ.size() > 0) chk(tag, video_pixel, pixQ.pop_front());
      end else if (video_pixel != 16'h0) nz++;
      vs += int'(hdmi_vSync);
      hs += int'(video_hSync);
      if (swapAt >= 0) begin
        isVSynced   = 1'b1;
        swapBuffers = (n == swapAt || n == swapAt + 4);
      end
    end
    swapBuffers = 1'b0;
    pixQ.delete();
    chk("deCount", de, PIX);
    chk("vSyncClocks", vs, 24);
    chk("hSyncClocks", hs, 24);
    chk("blankPixel", nz, 0);
  endtask

  initial begin
    int   n, r0;
    logic seen;
    swapBuffers = 0; isVSynced = 0; gpu_CtrlAddress = '0; gpu_CtrlAddressX = '0;
    gpu_CtrlAddressY = '0; gpu_CtrlImageWidth = '0; gpu_CtrlWidth = '0; gpu_CtrlHeight = '0;
    gpu_CtrlX = '0; gpu_CtrlY = '0; gpu_CtrlDraw = 0; gpu_CtrlClearColor = '0; gpu_CtrlClear = 0;

    repeat (3) @(posedge clk); #1;
    chk("rstBusy", gpu_CtrlBusy, 0);
    chk("rstMemRead", gpu_MemRead, 0);
    chk("rstMemAddr", gpu_MemAddr, 0);
    chk("rstDe", video_de, 0);
    chk("rstHSync", video_hSync, 0);
    chk("rstVSync", hdmi_vSync, 0);
    chk("rstPixel", video_pixel, 0);
    resetn = 1'b1;

    doClear(16'hD8B7, 1'b0, n);
    swapNow();
    checkFrame(1, -1, "clearPix");

    r0 = readCnt;
    doClear(16'h1234, 1'b1, n);

    r0 = readCnt;
    doDraw(32'h1000, 16'd3, 16'd2, 16'd10, 11'd2, 11'd1, 10'd2, 10'd1, n);
    chk("draw2x2Reads", readCnt - r0, 4);
    r0 = readCnt;
    doDraw(32'h2000, 16'd0, 16'd0, 16'd4, 11'd3, 11'd7, 10'd2, 10'd0, n);
    chk("edgeDrawReads", readCnt - r0, 6);

    checkFrame(1, 14, "vsyncHoldPix");
    frontM = 0;
    checkFrame(0, -1, "drawPix");
    checkFrame(0, -1, "collapsedSwapPix");

    r0 = readCnt;
    doDraw(32'h4000, 16'd0, 16'd0, 16'd4, 11'd0, 11'd0, 10'd2, 10'd0, n);
    chk("zeroWidthBusy", n, 1);
    chk("zeroWidthReads", readCnt - r0, 0);

    for (int jj = 0; jj < 2; jj++)
      for (int ii = 0; ii < 2; ii++) addrQ.push_back(32'h5000 + 32'((jj * 4 + ii) * 2));
    @(posedge clk); #1;
    gpu_CtrlAddress = 32'h5000; gpu_CtrlAddressX = '0; gpu_CtrlAddressY = '0;
    gpu_CtrlImageWidth = 16'd4; gpu_CtrlWidth = 11'd2; gpu_CtrlHeight = 10'd2;
    gpu_CtrlX = '0; gpu_CtrlY = '0; gpu_CtrlDraw = 1'b1;
    @(posedge clk); #1;
    gpu_CtrlDraw = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = gpu_MemRead;
    end
    chk("midDrawStrobe", {31'b0, seen}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("abortBusy", gpu_CtrlBusy, 0);
    chk("abortMemRead", gpu_MemRead, 0);
    chk("abortMemAddr", gpu_MemAddr, 0);
    repeat (4) @(posedge clk); #1;
    addrQ.delete();
    resetn = 1'b1;
    r0 = readCnt;
    frontM = 0;
    checkFrame(0, -1, "postResetPix");
    chk("postResetReads", readCnt - r0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
